// File: rtl/char_rot_pkg.sv
// Shared definitions for the rotating-character display driver.
//   - 2-bit character codes ('2', '5', '3', blank)
//   - active-low seven-segment patterns, bit order g..a (bit 0 = a)
//   - rotation direction encoding
//   - decode_char(): character code -> segment pattern
package char_rot_pkg;

    localparam logic [1:0] CH_2     = 2'b00;
    localparam logic [1:0] CH_5     = 2'b01;
    localparam logic [1:0] CH_3     = 2'b10;
    localparam logic [1:0] CH_BLANK = 2'b11;

    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // DIR_UP moves each character toward the next higher digit index.
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } rot_dir_e;

    function automatic logic [6:0] decode_char(input logic [1:0] code);
        logic [6:0] seg;
        case (code)
            CH_2:     seg = SEG_2;
            CH_5:     seg = SEG_5;
            CH_3:     seg = SEG_3;
            CH_BLANK: seg = SEG_BLANK;
            default:  seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/char_rot_seg_dec.sv
// Character decoder for one seven-segment display.
// Ports:
//   code_i  in  2  character code (see char_rot_pkg)
//   seg_o   out 7  active-low segments, bit order g..a
module char_rot_seg_dec
    import char_rot_pkg::*;
(
    input  logic [1:0] code_i,
    output logic [6:0] seg_o
);

    assign seg_o = decode_char(code_i);

endmodule

// File: rtl/char_rotator.sv
// Rotating-character display driver for a bank of seven-segment displays.
// Holds NUM_DIGITS 2-bit character codes, decodes each to active-low
// segments and rotates the word one position every TICK_DIV enabled cycles.
//
// Parameters:
//   NUM_DIGITS  number of characters/displays (2..6)
//   TICK_DIV    enabled clock cycles per rotation step (>= 2)
// Ports:
//   Clock      in  1             system clock
//   Resetn     in  1             asynchronous active-low reset
//   load       in  1             capture load_data into the character buffer
//   load_data  in  2*NUM_DIGITS  bits [2i+1:2i] -> digit i
//   enable     in  1             1: divider counts and rotation runs
//   dir        in  1             0: toward higher index, 1: toward lower
//   blink      in  1             (CHAR_ROT_BLINK_EN only) blank every other period
//   step       out 1             high during the cycle whose closing edge rotates
//   HEX        out 7*NUM_DIGITS  bits [7i+6:7i] drive HEXi, active-low g..a
//
// Build option: define CHAR_ROT_BLINK_EN to add the blink input and a phase
// flop toggled on every terminal count; with blink=1 and phase=1 every
// display is blanked without disturbing the buffer.
module char_rotator
    import char_rot_pkg::*;
#(
    parameter int NUM_DIGITS = 3,
    parameter int TICK_DIV   = 50_000_000
) (
    input  logic                    Clock,
    input  logic                    Resetn,
    input  logic                    load,
    input  logic [2*NUM_DIGITS-1:0] load_data,
    input  logic                    enable,
    input  logic                    dir,
`ifdef CHAR_ROT_BLINK_EN
    input  logic                    blink,
`endif
    output logic                    step,
    output logic [7*NUM_DIGITS-1:0] HEX
);

    localparam int              CNT_W   = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       chars_q [NUM_DIGITS];
    logic [1:0]       chars_d [NUM_DIGITS];
    logic             tc;
    logic [7*NUM_DIGITS-1:0] seg_raw;

    assign tc = enable && (cnt_q == CNT_MAX);

    // Load wins over a coincident terminal count: the loaded word appears
    // unrotated and the divider restarts from zero.
    always_comb begin
        cnt_d   = cnt_q;
        chars_d = chars_q;
        step    = 1'b0;
        if (load) begin
            cnt_d = '0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                chars_d[i] = load_data[2*i +: 2];
            end
        end else if (tc) begin
            cnt_d = '0;
            step  = 1'b1;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (rot_dir_e'(dir) == DIR_UP) begin
                    chars_d[i] = chars_q[(i + NUM_DIGITS - 1) % NUM_DIGITS];
                end else begin
                    chars_d[i] = chars_q[(i + 1) % NUM_DIGITS];
                end
            end
        end else if (enable) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            cnt_q <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                chars_q[i] <= CH_BLANK;
            end
        end else begin
            cnt_q <= cnt_d;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                chars_q[i] <= chars_d[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
        char_rot_seg_dec u_dec (
            .code_i (chars_q[g]),
            .seg_o  (seg_raw[7*g +: 7])
        );
    end

`ifdef CHAR_ROT_BLINK_EN
    logic phase_q, phase_d;

    always_comb begin
        phase_d = phase_q;
        if (load) begin
            phase_d = 1'b0;
        end else if (tc) begin
            phase_d = ~phase_q;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            phase_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign HEX = (blink && phase_q) ? {NUM_DIGITS{SEG_BLANK}} : seg_raw;
`else
    assign HEX = seg_raw;
`endif

endmodule

// File: tb/tb_char_rotator.sv
// Bench for char_rotator with NUM_DIGITS=3, TICK_DIV=4.
// The stimulus thread drives directed vectors and pushes the HEX word
// expected after each rotation into exp_q; the monitor pops and compares
// the cycle after every step pulse.
module tb_char_rotator;

    localparam int ND = 3;
    localparam int TD = 4;
    localparam int HW = 7 * ND;

    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] SB = 7'b1111111;

    // Words are written {HEX2, HEX1, HEX0}.
    localparam logic [HW-1:0] ALL_B = {SB, SB, SB};
    localparam logic [HW-1:0] W0    = {S3, S5, S2};  // load 6'b10_01_00
    localparam logic [HW-1:0] W0_R1 = {S5, S2, S3};  // one step dir=0
    localparam logic [HW-1:0] W0_R2 = {S2, S3, S5};  // two steps dir=0
    localparam logic [HW-1:0] W0_L1 = {S2, S3, S5};  // one step dir=1
    localparam logic [HW-1:0] W1    = {SB, S2, S5};  // load 6'b11_00_01
    localparam logic [HW-1:0] W1_L1 = {S5, SB, S2};  // one step dir=1

    logic            Clock = 1'b0;
    logic            Resetn = 1'b1;
    logic            load = 1'b0;
    logic [2*ND-1:0] load_data = '0;
    logic            enable = 1'b0;
    logic            dir = 1'b0;
`ifdef CHAR_ROT_BLINK_EN
    logic            blink = 1'b0;
`endif
    logic            step;
    logic [HW-1:0]   HEX;

    logic [HW-1:0] exp_q[$];
    int total = 0;
    int bad = 0;
    int steps_seen = 0;
    int steps_expected = 0;

    char_rotator #(.NUM_DIGITS(ND), .TICK_DIV(TD)) dut (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .load      (load),
        .load_data (load_data),
        .enable    (enable),
        .dir       (dir),
`ifdef CHAR_ROT_BLINK_EN
        .blink     (blink),
`endif
        .step      (step),
        .HEX       (HEX)
    );

    // ---------------- clock ----------------
    always #5 Clock = ~Clock;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string name, input logic [HW-1:0] act, input logic [HW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_word(input logic [HW-1:0] w);
        exp_q.push_back(w);
        steps_expected++;
    endtask

    // ---------------- scoreboard monitor ----------------
    always begin
        @(negedge Clock);
        if (Resetn && step) begin
            @(posedge Clock);
            #1;
            steps_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_step", HEX, ~HEX);
            end else begin
                check("hex_after_step", HEX, exp_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        // Reset
        #2 Resetn = 1'b0;
        #1;
        check("reset_hex", HEX, ALL_B);
        check("reset_step", HW'(step), HW'(0));
        tick();
        tick();
        Resetn = 1'b1;

        // Load word, then rotate dir=0 three times
        load = 1'b1;
        load_data = 6'b10_01_00;
        tick();
        load = 1'b0;
        enable = 1'b1;
        dir = 1'b0;
        check("load_hex", HEX, W0);
        expect_word(W0_R1);
        expect_word(W0_R2);
        expect_word(W0);
        for (int i = 0; i < TD - 1; i++) begin
            check("no_early_step", HW'(step), HW'(0));
            tick();
        end
        check("first_step", HW'(step), HW'(1));
        for (int i = 0; i < 2 * TD; i++) tick();
        check("third_step", HW'(step), HW'(1));
        tick();
        check("word_restored", HEX, W0);

        // Freeze mid-count, then resume with dir=1
        dir = 1'b1;
        tick();
        tick();
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("frozen_no_step", HW'(step), HW'(0));
            tick();
        end
        check("frozen_hex", HEX, W0);
        expect_word(W0_L1);
        enable = 1'b1;
        check("resume_cnt2", HW'(step), HW'(0));
        tick();
        check("resume_step", HW'(step), HW'(1));
        tick();

        // Load coincident with terminal count
        for (int i = 0; i < TD - 1; i++) tick();
        check("tc_pending", HW'(step), HW'(1));
        load = 1'b1;
        load_data = 6'b11_00_01;
        #1;
        check("load_masks_step", HW'(step), HW'(0));
        tick();
        load = 1'b0;
        check("load_unrotated", HEX, W1);
        expect_word(W1_L1);
        for (int i = 0; i < TD - 1; i++) begin
            check("post_load_no_step", HW'(step), HW'(0));
            tick();
        end
        check("post_load_step", HW'(step), HW'(1));
        tick();

        // Asynchronous reset between edges, mid-count
        tick();
        #2 Resetn = 1'b0;
        #1;
        check("async_reset_hex", HEX, ALL_B);
        check("async_reset_step", HW'(step), HW'(0));
        tick();
        Resetn = 1'b1;
        expect_word(ALL_B);
        for (int i = 0; i < TD - 1; i++) begin
            check("post_reset_no_step", HW'(step), HW'(0));
            tick();
        end
        check("post_reset_step", HW'(step), HW'(1));
        tick();

`ifdef CHAR_ROT_BLINK_EN
        // Blink: word for one period, blank for the next, tracking TC
        dir = 1'b0;
        blink = 1'b1;
        load = 1'b1;
        load_data = 6'b10_01_00;
        tick();
        load = 1'b0;
        expect_word(ALL_B);
        expect_word(W0_R2);
        for (int i = 0; i < TD; i++) begin
            check("blink_phase0", HEX, W0);
            tick();
        end
        for (int i = 0; i < TD; i++) begin
            check("blink_phase1", HEX, ALL_B);
            tick();
        end
        blink = 1'b0;
        expect_word(W0);
        for (int i = 0; i < TD; i++) begin
            check("blink_off", HEX, W0_R2);
            tick();
        end
        check("blink_off_phase1", HEX, W0);
`endif

        enable = 1'b0;
        tick();
        tick();
        check("queue_empty", HW'(exp_q.size()), HW'(0));
        check("step_count", HW'(steps_seen), HW'(steps_expected));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/char_rotator.md
# char_rotator

Parametrised rotating-character display driver for the DE1-SoC seven-segment bank. It holds NUM_DIGITS 2-bit character codes ('2', '5', '3', blank), decodes each to active-low segments, and rotates the word across the displays once per programmable tick. Rotation runs autonomously in either direction, replacing switch-selected rotation. It sits between board I/O (switches/keys) and the HEXn pins.

## Interface
- NUM_DIGITS, 3 — number of characters/displays; range 2..6.
- TICK_DIV, 50_000_000 — Clock cycles per rotation step; ≥ 2.
- Clock  in  1 — system clock (CLOCK_50 at top level).
- Resetn  in  1 — asynchronous, active-low reset.
- load  in  1 — capture load_data into the character buffer.
- load_data  in  2*NUM_DIGITS — character codes; bits [2i+1:2i] go to digit i.
- enable  in  1 — 1: divider counts and rotation runs; 0: frozen.
- dir  in  1 — 0: rotate toward higher digit index; 1: toward lower.
- step  out  1 — one-cycle pulse on every cycle where a rotation occurs.
- HEX  out  7*NUM_DIGITS — active-low segments; bits [7i+6:7i] drive HEXi, bit order g..a (bit 0 = a).

## Operation
- Character buffer: NUM_DIGITS × 2-bit registers, buf[i] shown on HEXi.
- Code map (active-low, g..a): 00 → '2' = 7'b0100100; 01 → '5' = 7'b0010010; 10 → '3' = 7'b0110000; 11 → blank = 7'b1111111.
- Divider: cnt counts 0..TICK_DIV-1 while enable=1; width $clog2(TICK_DIV); terminal count (TC) = (cnt == TICK_DIV-1) & enable; cnt wraps to 0 at TC.
- On TC (and no load), dir=0: buf[i] ← buf[i-1], buf[0] ← buf[NUM_DIGITS-1]. dir=1: buf[i] ← buf[i+1], buf[NUM_DIGITS-1] ← buf[0]. step=1 that cycle.
- enable=0: cnt holds its value, no rotation, step=0.
- load=1: buf ← load_data, cnt ← 0, step=0; load takes priority over a coincident TC (no rotation that cycle).
- dir change takes effect at the next TC; no realignment of cnt.
- HEX is combinational decode of buf.

## Timing
- Reset (Resetn=0, async): buf = all 11 (blank), cnt = 0, step = 0, HEX = all 1s. Takes effect immediately, including mid-rotation; first TC after release is TICK_DIV enabled cycles later.
- Load latency: data visible on HEX the cycle after the load edge.
- With enable held at 1 after load/reset, first step pulse occurs on the TICK_DIV-th cycle; thereafter every TICK_DIV cycles.
- step is registered-timed with the rotation: high during the cycle whose closing edge performs the shift; new HEX visible the next cycle.
- Full rotation returns to the original word after NUM_DIGITS steps.

## Configuration
- CHAR_ROT_BLINK_EN defined: adds input blink (1 bit) and a phase flop (reset 0) toggling on every TC; when blink=1 and phase=1, all HEX forced to 7'b1111111 (buf unaffected). load clears phase to 0.
- Not defined: no blink port, no phase flop; HEX always reflects buf.

## Structure
- Package char_rot_pkg: character code localparams (CH_2, CH_5, CH_3, CH_BLANK), SEG_BLANK constant, decode function/segment constants.
- One sub-module: char_rot_seg_dec (2-bit code → 7-bit active-low segments), instantiated NUM_DIGITS times via generate.
- Divider, buffer and rotation logic live in char_rotator.

## Test plan
- Reset mid-run: assert Resetn=0 asynchronously between edges → HEX = all 7'h7F immediately, step=0; after release no step for TICK_DIV cycles.
- NUM_DIGITS=3, TICK_DIV=4: load 6'b10_01_00 → next cycle HEX0=7'b0100100, HEX1=7'b0010010, HEX2=7'b0110000.
- enable=1, dir=0 → step pulses on 4th cycle; HEX0='3', HEX1='2', HEX2='5'; after 3 steps original word restored.
- dir=1 from original word → one step gives HEX0='5', HEX1='3', HEX2='2'.
- load coincident with TC → loaded word shown unrotated, step=0, next step 4 cycles later; enable=0 for 10 cycles mid-count → no steps, remaining count resumes unchanged.
- CHAR_ROT_BLINK_EN, blink=1 → HEX alternates word/blank every 4 cycles in step with TC; blink=0 → word constant.
